// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO and models multi-cycle
// mult/div latency through a down-counter and a busy flag.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] temp_hi_q, temp_hi_d;
  logic [31:0] temp_lo_q, temp_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  // Cleared on divide-by-zero so completion leaves HI/LO untouched.
  logic        wr_pend_q, wr_pend_d;

  // Multiply: sign- or zero-extend to 64 bits; the low 64 product bits are exact.
  logic [63:0] ext_a, ext_b, product;
  assign ext_a   = {(op == OpMult) ? {32{A[31]}} : 32'h0, A};
  assign ext_b   = {(op == OpMult) ? {32{B[31]}} : 32'h0, B};
  assign product = ext_a * ext_b;

  // Signed divide via magnitudes; avoids the INT_MIN / -1 overflow case entirely.
  logic [31:0] a_mag, b_mag, b_safe, sq_mag, sr_mag, s_quot, s_rem;
  logic [31:0] bu_safe, u_quot, u_rem;
  assign a_mag   = A[31] ? (32'h0 - A) : A;
  assign b_mag   = B[31] ? (32'h0 - B) : B;
  assign b_safe  = (b_mag == 32'h0) ? 32'h1 : b_mag;
  assign sq_mag  = a_mag / b_safe;
  assign sr_mag  = a_mag % b_safe;
  assign s_quot  = (A[31] ^ B[31]) ? (32'h0 - sq_mag) : sq_mag;
  assign s_rem   = A[31] ? (32'h0 - sr_mag) : sr_mag;
  assign bu_safe = (B == 32'h0) ? 32'h1 : B;
  assign u_quot  = A / bu_safe;
  assign u_rem   = A % bu_safe;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    wr_pend_d = wr_pend_q;
    unique case (state_q)
      StIdle: begin
        case (op)
          OpMult, OpMultu: begin
            temp_hi_d = product[63:32];
            temp_lo_d = product[31:0];
            count_d   = MultCnt;
            wr_pend_d = 1'b1;
            state_d   = StBusy;
          end
          OpDiv: begin
            temp_hi_d = s_rem;
            temp_lo_d = s_quot;
            count_d   = DivCnt;
            wr_pend_d = (B != 32'h0);
            state_d   = StBusy;
          end
          OpDivu: begin
            temp_hi_d = u_rem;
            temp_lo_d = u_quot;
            count_d   = DivCnt;
            wr_pend_d = (B != 32'h0);
            state_d   = StBusy;
          end
          OpMthi:  hi_d = A;
          OpMtlo:  lo_d = A;
          default: ;
        endcase
      end
      StBusy: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = StIdle;
          if (wr_pend_q) begin
            hi_d = temp_hi_q;
            lo_d = temp_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= 4'h0;
      temp_hi_q <= 32'h0;
      temp_lo_q <= 32'h0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  assign busy = (state_q == StBusy);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: mult/div results, busy latency,
// mthi/mtlo, ignored ops while busy, divide-by-zero and reset mid-operation.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int checks   = 0;
  int failures = 0;

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op at the next edge, then expect exactly n busy samples.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int n, input string tag);
    op = o; A = a; B = b;
    step();
    op = 3'd0; A = 32'h0; B = 32'h0;
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_busy"}, {31'h0, busy}, 32'h1);
      step();
    end
    check_eq({tag, "_done"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; op = 3'd1; A = 32'h7; B = 32'h9;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_busy", {31'h0, busy}, 32'h0);
      check_eq("rst_hi", HI, 32'h0);
      check_eq("rst_lo", LO, 32'h0);
    end
    reset = 1'b0; op = 3'd0;

    run_op(3'd1, 32'hFFFF_FFFF, 32'h2, 5, "mult");
    check_eq("mult_hi", HI, 32'hFFFF_FFFF);
    check_eq("mult_lo", LO, 32'hFFFF_FFFE);

    run_op(3'd2, 32'hFFFF_FFFF, 32'h2, 5, "multu");
    check_eq("multu_hi", HI, 32'h0000_0001);
    check_eq("multu_lo", LO, 32'hFFFF_FFFE);

    run_op(3'd3, 32'hFFFF_FFF9, 32'h2, 10, "div");
    check_eq("div_hi", HI, 32'hFFFF_FFFF);
    check_eq("div_lo", LO, 32'hFFFF_FFFD);

    run_op(3'd4, 32'hFFFF_FFF9, 32'h2, 10, "divu");
    check_eq("divu_hi", HI, 32'h0000_0001);
    check_eq("divu_lo", LO, 32'h7FFF_FFFC);

    run_op(3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 10, "div_pn");
    check_eq("div_pn_hi", HI, 32'h0000_0001);
    check_eq("div_pn_lo", LO, 32'hFFFF_FFFD);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_ovf");
    check_eq("div_ovf_hi", HI, 32'h0000_0000);
    check_eq("div_ovf_lo", LO, 32'h8000_0000);

    // Divide by zero keeps prior HI/LO (LO still holds the overflow quotient).
    op = 3'd5; A = 32'h1234_5678;
    step();
    op = 3'd0;
    check_eq("mthi", HI, 32'h1234_5678);
    run_op(3'd3, 32'h5, 32'h0, 10, "divz");
    check_eq("divz_hi", HI, 32'h1234_5678);
    check_eq("divz_lo", LO, 32'h8000_0000);

    op = 3'd6; A = 32'h0000_ABCD;
    step();
    op = 3'd0;
    check_eq("mtlo", LO, 32'h0000_ABCD);

    // Ops presented while busy must be dropped.
    op = 3'd1; A = 32'h3; B = 32'h4;
    step();
    op = 3'd6; A = 32'h0000_DEAD;
    check_eq("ign_busy1", {31'h0, busy}, 32'h1);
    step();
    op = 3'd1; A = 32'h5; B = 32'h5;
    check_eq("ign_busy2", {31'h0, busy}, 32'h1);
    check_eq("ign_lo_mid", LO, 32'h0000_ABCD);
    step();
    op = 3'd0; A = 32'h0; B = 32'h0;
    check_eq("ign_busy3", {31'h0, busy}, 32'h1);
    step();
    check_eq("ign_busy4", {31'h0, busy}, 32'h1);
    step();
    check_eq("ign_busy5", {31'h0, busy}, 32'h1);
    step();
    check_eq("ign_done", {31'h0, busy}, 32'h0);
    check_eq("ign_hi", HI, 32'h0);
    check_eq("ign_lo", LO, 32'd12);
    step();
    check_eq("ign_nobusy", {31'h0, busy}, 32'h0);

    // Reset during the 4th busy cycle of a div discards the result.
    op = 3'd3; A = 32'd100; B = 32'd7;
    step();
    op = 3'd0;
    for (int i = 0; i < 3; i++) begin
      check_eq("rdiv_busy", {31'h0, busy}, 32'h1);
      step();
    end
    check_eq("rdiv_busy4", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rdiv_busy_clr", {31'h0, busy}, 32'h0);
    check_eq("rdiv_hi_clr", HI, 32'h0);
    check_eq("rdiv_lo_clr", LO, 32'h0);
    for (int i = 0; i < 12; i++) step();
    check_eq("rdiv_busy_late", {31'h0, busy}, 32'h0);
    check_eq("rdiv_hi_late", HI, 32'h0);
    check_eq("rdiv_lo_late", LO, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the EX stage of the pipelined MIPS core. It consumes the forwarded rs/rt operands produced by the EX-stage 4-input forwarding multiplexers and owns the HI/LO registers. Its HI/LO outputs feed the 8-input EX result multiplexer that serves mfhi/mflo. The unit models multi-cycle mult/div latency with a busy flag, which the hazard unit uses to stall.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- op  in  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
- A  in  32  forwarded rs operand
- B  in  32  forwarded rt operand
- busy  out  1  registered; high while a mult/div is in flight
- HI  out  32  HI register contents
- LO  out  32  LO register contents

## Operation
- Two states: IDLE (count==0, busy=0) and BUSY (count!=0, busy=1). There is a 4-bit down-counter `count`.
- IDLE, op=1..4 at a clock edge:
  - Compute the result from A/B sampled at that edge into 32-bit temp_hi/temp_lo.
  - Load count with MULT_CYCLES (ops 1/2) or DIV_CYCLES (ops 3/4).
  - Enter BUSY. HI/LO are unchanged.
- BUSY: count decrements each edge. On the edge where count==1:
  - HI<=temp_hi and LO<=temp_lo.
  - count becomes 0, so busy falls and the unit returns to IDLE.
- mult: signed 32x32 to 64-bit; HI=product[63:32], LO=product[31:0]. multu is the unsigned form.
- div: signed. LO=quotient, truncated toward zero. HI=remainder, which takes the sign of the dividend A.
  - Special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B==0, div or divu): the unit still goes busy for DIV_CYCLES, but HI/LO keep their prior values at completion.
- mthi (5): HI<=A at the edge. mtlo (6): LO<=A at the edge. Both take effect only in IDLE.
- Any op while BUSY, including mthi/mtlo, is ignored. The upstream hazard unit stalls any md-class instruction while busy is high. The unit never queues.
- op=0/7: no state change.

## Timing
- Reset values: busy=0, HI=0, LO=0, count=0, temp_hi=0, temp_lo=0.
- Reset takes priority over every op. Reset mid-operation discards the pending result, and HI/LO read 0 the cycle after.
- The cycle op=mult is presented, busy is still 0. Hazard logic must treat (op in 1..4) | busy as busy.
- Mult issued at edge t:
  - busy=1 during cycles t+1 .. t+MULT_CYCLES.
  - HI/LO hold the new values, and busy=0, from edge t+MULT_CYCLES.
- Div follows the same pattern with DIV_CYCLES.
- Back-to-back: a new start is accepted at the same edge where busy falls only if op arrives in IDLE, i.e. the edge after busy reads 0. No overlap.
- mthi/mtlo latency is one edge. The value is readable on HI/LO the next cycle.
- HI/LO are pure register outputs with no bypass of temp values or of A.

## Test plan
- Reset with op=1 (mult) held: HI=LO=0 and busy=0 throughout. Release reset, then mult A=0xFFFFFFFF, B=2 → busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div A=0xFFFFFFF9 (-7), B=2:
  - Expect 10 busy cycles, then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1).
  - divu with the same operands gives LO=0x7FFFFFFC, HI=1.
- Divide-by-zero: mthi 0x12345678, then div A=5, B=0 → busy 10 cycles, HI stays 0x12345678, LO is unchanged.
- While busy, present mtlo A=0xDEAD and a second mult → both ignored. The first result lands at the original completion edge and LO≠0xDEAD.
- Assert reset at the 4th busy cycle of a div → next cycle busy=0, HI=LO=0, and no later write occurs.
